// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int unsigned KEEP_MAX = 32;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_FILL,
    ACC_DONE
  } acc_state_t;

  // Lane-valid mask with the low cnt lanes set; callers slice to their lane count.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned cnt);
    logic [KEEP_MAX-1:0] m;
    if (cnt >= KEEP_MAX) m = '1;
    else                 m = (KEEP_MAX'(1) << cnt) - KEEP_MAX'(1);
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port, flush request and packed output stream of the read-side packer.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);
  logic                             fifo_empty;
  logic [DATA_WIDTH-1:0]            fifo_rdata;
  logic                             fifo_ren;
  logic                             flush;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;

  modport master (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_ren, out_valid, out_data, out_keep
  );

  modport slave (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_ren, out_valid, out_data, out_keep
  );
endinterface

// File: rtl/fifo_rd_pack_acc.sv
// Lane register file, lane counter and accumulator FSM of the read-side packer.
//   state    | meaning
//   ACC_IDLE | no lanes filled
//   ACC_FILL | some lanes filled, word still open
//   ACC_DONE | word sealed (full or flushed), waiting for the output register
module fifo_rd_pack_acc
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             pop_i,
  input  logic                             flush_i,
  input  logic                             xfer_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] acc_word_o,
  output logic [PACK_RATIO-1:0]            acc_keep_o,
  output logic                             acc_done_o,
  output logic                             acc_fill_o
);

  localparam int CW = $clog2(PACK_RATIO);

  acc_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, lane_idx;
  logic [DATA_WIDTH-1:0] lanes_q [PACK_RATIO];
  logic [DATA_WIDTH-1:0] lanes_d [PACK_RATIO];
  logic                  last_lane;
  logic [KEEP_MAX-1:0]   mask_full;
  logic                  unused_mask;

  always_comb begin
    // A transfer empties the accumulator, so a same-cycle pop lands in lane 0.
    lane_idx  = xfer_i ? '0 : cnt_q;
    last_lane = pop_i && (lane_idx == CW'(PACK_RATIO - 1));
    cnt_d     = pop_i ? lane_idx + CW'(1) : lane_idx;
    for (int i = 0; i < PACK_RATIO; i++) begin
      lanes_d[i] = xfer_i ? '0 : lanes_q[i];
      if (pop_i && (lane_idx == CW'(i))) lanes_d[i] = data_i;
    end

    state_d = state_q;
    unique case (state_q)
      ACC_IDLE: if (pop_i) state_d = ACC_FILL;
      ACC_FILL: if (last_lane || flush_i) state_d = ACC_DONE;
      ACC_DONE: if (xfer_i) state_d = pop_i ? ACC_FILL : ACC_IDLE;
      default:  state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACC_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < PACK_RATIO; i++) lanes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < PACK_RATIO; i++) lanes_q[i] <= lanes_d[i];
    end
  end

  for (genvar g = 0; g < PACK_RATIO; g++) begin : g_word
    assign acc_word_o[g*DATA_WIDTH +: DATA_WIDTH] = lanes_q[g];
  end

  // A full word wraps the counter to 0; a flushed word leaves it at the lane count.
  assign mask_full   = keep_mask(32'(cnt_q));
  assign unused_mask = ^mask_full;
  assign acc_keep_o  = (cnt_q == '0) ? '1 : mask_full[PACK_RATIO-1:0];
  assign acc_done_o  = (state_q == ACC_DONE);
  assign acc_fill_o  = (state_q == ACC_FILL);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer packing PACK_RATIO entries into one keep-masked stream word.
// Macro PACKER_TIMEOUT_FLUSH_EN adds an idle-timeout auto-flush of partial words.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              r_clk,
  input logic              r_rst,
  fifo_rd_packer_if.master bus
);

  localparam int WW = DATA_WIDTH * PACK_RATIO;

  if (PACK_RATIO < 2 || (PACK_RATIO & (PACK_RATIO - 1)) != 0 ||
      PACK_RATIO > KEEP_MAX || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("fifo_rd_packer: unsupported parameter values");
  end

  logic                  acc_done, acc_fill, pop, xfer, flush_any, tmo_flush;
  logic [WW-1:0]         acc_word, out_data_q;
  logic [PACK_RATIO-1:0] acc_keep, out_keep_q;
  logic                  out_valid_q;

  assign xfer = acc_done && (!out_valid_q || bus.out_ready);
  // Popping in ACC_DONE is allowed only when the sealed word leaves this cycle,
  // which keeps the stream free of bubbles at word boundaries.
  assign bus.fifo_ren = !r_rst && !bus.fifo_empty && (!acc_done || xfer);
  assign pop          = bus.fifo_ren;
  assign flush_any    = bus.flush || tmo_flush;

  fifo_rd_pack_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_RATIO (PACK_RATIO)
  ) u_acc (
    .clk_i      (r_clk),
    .rst_i      (r_rst),
    .pop_i      (pop),
    .flush_i    (flush_any),
    .xfer_i     (xfer),
    .data_i     (bus.fifo_rdata),
    .acc_word_o (acc_word),
    .acc_keep_o (acc_keep),
    .acc_done_o (acc_done),
    .acc_fill_o (acc_fill)
  );

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_word;
      out_keep_q  <= acc_keep;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;

`ifdef PACKER_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;

  // Down-counter reloaded on activity; fires on the TIMEOUT_CYCLES-th idle cycle.
  always_comb begin
    idle_d = idle_q;
    if (pop || !acc_fill)   idle_d = TW'(TIMEOUT_CYCLES - 1);
    else if (idle_q != '0)  idle_d = idle_q - TW'(1);
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) idle_q <= TW'(TIMEOUT_CYCLES - 1);
    else       idle_q <= idle_d;
  end

  assign tmo_flush = acc_fill && !pop && (idle_q == '0);
`else
  logic unused_fill;
  assign unused_fill = acc_fill;
  assign tmo_flush   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized and directed checks of fifo_rd_packer against a queue-based stream model.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int T  = 16;
  localparam int WW = DW * R;

  logic r_clk = 1'b0;
  logic r_rst = 1'b0;
  always #5 r_clk = ~r_clk;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(R)) bus ();

  fifo_rd_packer #(
    .DATA_WIDTH     (DW),
    .PACK_RATIO     (R),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int dut_pops = 0;

  logic [DW-1:0]   src_q[$];
  logic [DW-1:0]   cur[$];
  logic [DW-1:0]   seal_lanes[$];
  bit              sealed = 1'b0;
  logic [WW+R-1:0] outreg_q[$];
  int              idle_n = 0;
  logic [WW-1:0]   got_data[$];
  logic [R-1:0]    got_keep[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW+R-1:0] pack(input logic [DW-1:0] l[$]);
    logic [WW-1:0] d;
    logic [R-1:0]  k;
    d = '0;
    k = '0;
    foreach (l[i]) begin
      d[i*DW +: DW] = l[i];
      k[i] = 1'b1;
    end
    return {k, d};
  endfunction

  task automatic cycle(input bit rdy, input bit fl);
    bit xfer, eren, fill, fl_eff;
    @(negedge r_clk);
    bus.fifo_empty = (src_q.size() == 0);
    bus.fifo_rdata = (src_q.size() != 0) ? src_q[0] : '0;
    bus.flush      = fl;
    bus.out_ready  = rdy;
    #1;
    xfer = sealed && (outreg_q.size() == 0 || rdy);
    eren = (src_q.size() != 0) && (!sealed || xfer);
    chk("fifo_ren", 64'(bus.fifo_ren), 64'(eren));
    chk("out_valid", 64'(bus.out_valid), 64'(outreg_q.size() != 0));
    if (outreg_q.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(outreg_q[0][WW-1:0]));
      chk("out_keep", 64'(bus.out_keep), 64'(outreg_q[0][WW+R-1:WW]));
    end
    if (bus.fifo_ren && !bus.fifo_empty) dut_pops++;
    if (bus.out_valid && rdy) begin
      got_data.push_back(bus.out_data);
      got_keep.push_back(bus.out_keep);
    end

    fill   = !sealed && (cur.size() != 0);
    fl_eff = fill && fl;
`ifdef PACKER_TIMEOUT_FLUSH_EN
    if (fill && !eren) begin
      if (idle_n + 1 == T) fl_eff = 1'b1;
      idle_n++;
    end else begin
      idle_n = 0;
    end
`endif
    if (outreg_q.size() != 0 && rdy) void'(outreg_q.pop_front());
    if (xfer) begin
      outreg_q.push_back(pack(seal_lanes));
      seal_lanes.delete();
      sealed = 1'b0;
    end
    if (eren) cur.push_back(src_q.pop_front());
    if (fl_eff || cur.size() == R) begin
      seal_lanes = cur;
      cur.delete();
      sealed = 1'b1;
    end
    @(posedge r_clk);
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    r_rst          = 1'b1;
    bus.fifo_empty = 1'b0;
    bus.fifo_rdata = 8'h5a;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_ren", 64'(bus.fifo_ren), 64'(0));
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_data", 64'(bus.out_data), 64'(0));
      chk("rst_keep", 64'(bus.out_keep), 64'(0));
      @(negedge r_clk);
    end
    bus.fifo_empty = 1'b1;
    r_rst = 1'b0;
    src_q.delete();
    cur.delete();
    seal_lanes.delete();
    sealed = 1'b0;
    outreg_q.delete();
    idle_n = 0;
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [WW-1:0] d,
                          input logic [R-1:0] k);
    logic [WW-1:0] gd;
    logic [R-1:0]  gk;
    gd = 'x;
    gk = 'x;
    if (idx < got_data.size()) begin
      gd = got_data[idx];
      gk = got_keep[idx];
    end
    chk({tag, "_data"}, 64'(gd), 64'(d));
    chk({tag, "_keep"}, 64'(gk), 64'(k));
  endtask

  task automatic clear_got();
    got_data.delete();
    got_keep.delete();
  endtask

  initial begin
    int p0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    do_reset();

    // Full word, streaming downstream.
    clear_got();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (8) cycle(1'b1, 1'b0);
    chk("t1_beats", 64'(got_data.size()), 64'(1));
    chk_word("t1", 0, 32'h44332211, 4'b1111);

    // Backpressure: two words buffered, FIFO left non-empty, then drain.
    clear_got();
    for (int i = 1; i <= 12; i++) src_q.push_back(8'(8'ha0 + i));
    p0 = dut_pops;
    repeat (14) cycle(1'b0, 1'b0);
    chk("t2_pops_held", 64'(dut_pops - p0), 64'(8));
    chk("t2_no_beat", 64'(got_data.size()), 64'(0));
    repeat (10) cycle(1'b1, 1'b0);
    chk("t2_beats", 64'(got_data.size()), 64'(3));
    chk_word("t2_w0", 0, 32'ha4a3a2a1, 4'b1111);
    chk_word("t2_w1", 1, 32'ha8a7a6a5, 4'b1111);
    chk_word("t2_w2", 2, 32'hacabaaa9, 4'b1111);

    // Partial flush, then flush while idle.
    clear_got();
    src_q = '{8'haa, 8'hbb};
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b0);
    chk_word("t3", 0, 32'h0000bbaa, 4'b0011);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b0);
    chk("t3_idle_flush", 64'(got_data.size()), 64'(1));

    // Flush coinciding with the last lane.
    clear_got();
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b1, 1'b0);
    chk("t4_beats", 64'(got_data.size()), 64'(1));
    chk_word("t4", 0, 32'h04030201, 4'b1111);

    // Reset mid-word discards the partial word.
    clear_got();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (2) cycle(1'b1, 1'b0);
    do_reset();
    src_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    repeat (7) cycle(1'b1, 1'b0);
    chk("t5_beats", 64'(got_data.size()), 64'(1));
    chk_word("t5", 0, 32'h88776655, 4'b1111);

    // Idle partial word: auto-flush when enabled, explicit flush otherwise.
    clear_got();
    src_q = '{8'h01, 8'h02, 8'h03};
`ifdef PACKER_TIMEOUT_FLUSH_EN
    repeat (3 + T - 1) cycle(1'b1, 1'b0);
    chk("t6_early", 64'(got_data.size()), 64'(0));
    repeat (4) cycle(1'b1, 1'b0);
`else
    repeat (103) cycle(1'b1, 1'b0);
    chk("t6_no_timeout", 64'(got_data.size()), 64'(0));
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
`endif
    chk("t6_beats", 64'(got_data.size()), 64'(1));
    chk_word("t6", 0, 32'h00030201, 4'b0111);

    // Random traffic, backpressure, flushes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) clear_got();
      if (src_q.size() < 12 && $urandom_range(0, 9) < 6) src_q.push_back(8'($urandom));
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
